// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: per-mode half-periods, clock-stretch aware, with
// single-cycle SDA-change / SDA-sample / period-end strobes.
module i2c_scl_gen #(
  parameter int CNT_W    = 12,
  parameter int HALF_SM  = 2500,
  parameter int HALF_FM  = 625,
  parameter int HALF_FMP = 250,
  parameter int HALF_HS  = 74
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] clk_config,
  input  logic       scl_in,
  output logic       scl_out,
  output logic       busy,
  output logic       sda_en,
  output logic       sample_stb,
  output logic       period_end,
  output logic       stretching
);

  // Half-periods below 2 would make the mid-phase strobes collide with the
  // phase boundaries, so every mode is clamped to 2.
  localparam int SM_C  = (HALF_SM  < 2) ? 2 : HALF_SM;
  localparam int FM_C  = (HALF_FM  < 2) ? 2 : HALF_FM;
  localparam int FMP_C = (HALF_FMP < 2) ? 2 : HALF_FMP;
  localparam int HS_C  = (HALF_HS  < 2) ? 2 : HALF_HS;
  localparam logic [CNT_W-1:0] L_SM  = SM_C[CNT_W-1:0];
  localparam logic [CNT_W-1:0] L_FM  = FM_C[CNT_W-1:0];
  localparam logic [CNT_W-1:0] L_FMP = FMP_C[CNT_W-1:0];
  localparam logic [CNT_W-1:0] L_HS  = HS_C[CNT_W-1:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] w_half_sel;
  logic [CNT_W-1:0] w_half_m1;
  logic [CNT_W-1:0] w_half_mid;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_scl_s;
  logic             w_latch;
  logic             w_sda_cond;
  logic             w_samp_cond;
  logic             w_pe_next;
  logic             w_str_next;

  logic r_scl_out;
  logic r_busy;
  logic r_sda_en;
  logic r_sample_stb;
  logic r_period_end;
  logic r_stretching;

  assign w_scl_s    = r_sync2;
  assign w_half_m1  = r_half - CNT_W'(1);
  assign w_half_mid = r_half >> 1;

  always_comb begin
    case (clk_config)
      2'b00:   w_half_sel = L_SM;
      2'b01:   w_half_sel = L_FM;
      2'b10:   w_half_sel = L_FMP;
      default: w_half_sel = L_HS;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_sda_cond   = 1'b0;
    w_samp_cond  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (en) begin
          w_state_next = ST_LOW;
          w_latch      = 1'b1;
        end
      end
      ST_LOW: begin
        w_sda_cond = (r_cnt == w_half_mid);
        if (r_cnt == w_half_m1) begin
          w_state_next = ST_HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        // Counter freezes while the bus is held low by a slave.
        if (w_scl_s) begin
          w_samp_cond = (r_cnt == w_half_mid);
          if (r_cnt == w_half_m1) begin
            w_cnt_next = '0;
            if (en) begin
              w_state_next = ST_LOW;
              w_latch      = 1'b1;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // period_end and stretching are computed one cycle ahead (r_sync1 is the
  // next scl_s) so the registered strobe lands on the HIGH cycle it describes.
  assign w_pe_next  = (w_state_next == ST_HIGH) && r_sync1 && (w_cnt_next == w_half_m1);
  assign w_str_next = (w_state_next == ST_HIGH) && !r_sync1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_half       <= L_SM;
      r_scl_out    <= 1'b1;
      r_busy       <= 1'b0;
      r_sda_en     <= 1'b0;
      r_sample_stb <= 1'b0;
      r_period_end <= 1'b0;
      r_stretching <= 1'b0;
    end else begin
      r_sync1      <= scl_in;
      r_sync2      <= r_sync1;
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      if (w_latch) begin
        r_half <= w_half_sel;
      end
      r_scl_out    <= (w_state_next != ST_LOW);
      r_busy       <= (w_state_next != ST_IDLE);
      r_sda_en     <= w_sda_cond;
      r_sample_stb <= w_samp_cond;
      r_period_end <= w_pe_next;
      r_stretching <= w_str_next;
    end
  end

  assign scl_out    = r_scl_out;
  assign busy       = r_busy;
  assign sda_en     = r_sda_en;
  assign sample_stb = r_sample_stb;
  assign period_end = r_period_end;
  assign stretching = r_stretching;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Self-checking bench for i2c_scl_gen: a negedge monitor turns each SCL period
// into a record that is compared against expected records queued by each test.
module tb_i2c_scl_gen;

  typedef struct packed {
    int low;
    int high;
    int sda_off;
    int samp_off;
    int n_sda;
    int n_samp;
    int ovl;
    int str;
  } rec_t;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] clk_config = 2'b11;
  logic       force_low = 1'b0;
  logic       scl_in;
  logic       scl_out, busy, sda_en, sample_stb, period_end, stretching;

  logic       en2 = 1'b0;
  logic [1:0] cfg2 = 2'b11;
  logic       scl_out2, busy2, sda_en2, sample_stb2, period_end2, stretching2;

  logic sel = 1'b0;
  logic m_scl, m_busy, m_sda, m_samp, m_pe, m_str;

  int   errors = 0;
  int   checks = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];
  rec_t cur;
  rec_t e, o;
  int   cyc = 0, fall_t = 0, rise_t = 0;
  logic pend = 1'b0, prev = 1'b1;

  always #5 clk_in = ~clk_in;

  assign scl_in = scl_out & ~force_low;

  i2c_scl_gen dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .clk_config(clk_config),
    .scl_in(scl_in), .scl_out(scl_out), .busy(busy), .sda_en(sda_en),
    .sample_stb(sample_stb), .period_end(period_end), .stretching(stretching)
  );

  i2c_scl_gen #(.HALF_HS(1)) dut_c (
    .clk_in(clk_in), .rst_n(rst_n), .en(en2), .clk_config(cfg2),
    .scl_in(scl_out2), .scl_out(scl_out2), .busy(busy2), .sda_en(sda_en2),
    .sample_stb(sample_stb2), .period_end(period_end2), .stretching(stretching2)
  );

  assign m_scl  = sel ? scl_out2    : scl_out;
  assign m_busy = sel ? busy2       : busy;
  assign m_sda  = sel ? sda_en2     : sda_en;
  assign m_samp = sel ? sample_stb2 : sample_stb;
  assign m_pe   = sel ? period_end2 : period_end;
  assign m_str  = sel ? stretching2 : stretching;

  // Period monitor: a record closes on the cycle after period_end, so a
  // sample strobe landing there still belongs to the period it sampled.
  always @(negedge clk_in) begin
    if (!rst_n) begin
      prev = 1'b1;
      pend = 1'b0;
      cur  = '0;
    end else begin
      cyc = cyc + 1;
      if (m_sda) begin
        cur.n_sda   = cur.n_sda + 1;
        cur.sda_off = cyc - fall_t;
      end
      if (m_samp) begin
        cur.n_samp   = cur.n_samp + 1;
        cur.samp_off = cyc - rise_t;
      end
      if (int'(m_sda) + int'(m_samp) + int'(m_pe) > 1) cur.ovl = 1;
      if (m_str) cur.str = cur.str + 1;
      if (pend) begin
        obs_q.push_back(cur);
        cur  = '0;
        pend = 1'b0;
      end
      if (prev && !m_scl) fall_t = cyc;
      if (!prev && m_scl) begin
        rise_t  = cyc;
        cur.low = cyc - fall_t;
      end
      if (m_pe) begin
        cur.high = cyc - rise_t + 1;
        pend     = 1'b1;
      end
      prev = m_scl;
    end
  end

  function automatic rec_t mk(input int h, input int s);
    rec_t r;
    r.low      = h;
    r.high     = h + 2 + s;
    r.sda_off  = (h / 2) + 1;
    r.samp_off = (h / 2) + 3 + s;
    r.n_sda    = 1;
    r.n_samp   = 1;
    r.ovl      = 0;
    r.str      = 2 + s;
    return r;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("low=%0d high=%0d sda=%0d samp=%0d nsda=%0d nsamp=%0d ovl=%0d str=%0d",
                     r.low, r.high, r.sda_off, r.samp_off, r.n_sda, r.n_samp, r.ovl, r.str);
  endfunction

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk_in);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && m_busy; i++) @(negedge clk_in);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (scl_out !== 1'b1) begin errors++; $display("FAIL rst_scl: got %b need 1", scl_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
    checks++;
    if ({sda_en, sample_stb, period_end, stretching} !== 4'b0) begin
      errors++; $display("FAIL rst_strobes: got %b need 0000", {sda_en, sample_stb, period_end, stretching});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
    checks++;
    if ({scl_out, busy} !== 2'b10) begin
      errors++; $display("FAIL idle_after_rst: got scl/busy=%b need 10", {scl_out, busy});
    end
  endtask

  task automatic test_hs;
    clk_config = 2'b11;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(74, 0));
    en = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({scl_out, busy} !== 2'b01) begin
      errors++; $display("FAIL en_to_low: got scl/busy=%b need 01", {scl_out, busy});
    end
    wait_obs(2, 400);
    en = 1'b0;
    wait_obs(3, 300);
    wait_idle(50);
    checks++;
    if (obs_q.size() < exp_q.size()) begin
      errors++; $display("FAIL hs_timeout: got %0d records need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL hs_period: got %s need %s", fmt(o), fmt(e)); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_sm_stop;
    logic seen;
    seen = 1'b0;
    clk_config = 2'b00;
    exp_q.push_back(mk(2500, 0));
    en = 1'b1;
    repeat (100) @(negedge clk_in);
    en = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk_in);
      seen = period_end;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL sm_period_end: got none need 1"); end
    @(negedge clk_in);
    checks++;
    if ({scl_out, busy} !== 2'b10) begin
      errors++; $display("FAIL sm_stop: got scl/busy=%b need 10", {scl_out, busy});
    end
    wait_obs(1, 20);
    checks++;
    if (obs_q.size() < exp_q.size()) begin
      errors++; $display("FAIL sm_timeout: got %0d records need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL sm_period: got %s need %s", fmt(o), fmt(e)); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stretch;
    clk_config = 2'b11;
    exp_q.push_back(mk(74, 100));
    en = 1'b1;
    @(negedge clk_in);
    for (int i = 0; i < 200 && !scl_out; i++) @(negedge clk_in);
    en = 1'b0;
    repeat (10) @(negedge clk_in);
    force_low = 1'b1;
    repeat (50) @(negedge clk_in);
    checks++;
    if ({stretching, sample_stb, scl_out} !== 3'b101) begin
      errors++; $display("FAIL mid_stretch: got str/samp/scl=%b need 101", {stretching, sample_stb, scl_out});
    end
    repeat (50) @(negedge clk_in);
    force_low = 1'b0;
    wait_obs(1, 300);
    wait_idle(20);
    checks++;
    if (obs_q.size() < exp_q.size()) begin
      errors++; $display("FAIL stretch_timeout: got %0d records need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL stretch_period: got %s need %s", fmt(o), fmt(e)); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mode_change;
    clk_config = 2'b11;
    exp_q.push_back(mk(74, 0));
    exp_q.push_back(mk(250, 0));
    en = 1'b1;
    repeat (21) @(negedge clk_in);
    clk_config = 2'b10;
    wait_obs(1, 300);
    en = 1'b0;
    wait_obs(2, 700);
    wait_idle(20);
    checks++;
    if (obs_q.size() < exp_q.size()) begin
      errors++; $display("FAIL mode_timeout: got %0d records need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL mode_period: got %s need %s", fmt(o), fmt(e)); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic seen;
    seen = 1'b0;
    clk_config = 2'b10;
    exp_q.push_back(mk(250, 0));
    en = 1'b1;
    for (int i = 0; i < 700 && !seen; i++) begin
      @(negedge clk_in);
      seen = period_end;
    end
    en = 1'b0;
    checks++;
    if (!seen || busy !== 1'b1) begin
      errors++; $display("FAIL pe_busy: got seen=%b busy=%b need 1 1", seen, busy);
    end
    @(negedge clk_in);
    checks++;
    if ({scl_out, busy} !== 2'b10) begin
      errors++; $display("FAIL en_at_pe: got scl/busy=%b need 10", {scl_out, busy});
    end
    wait_obs(1, 20);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_period: got %s need %s", fmt(o), fmt(e)); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout: got 0 records need 1"); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset;
    clk_config = 2'b10;
    en = 1'b1;
    repeat (260) @(negedge clk_in);
    checks++;
    if ({scl_out, busy} !== 2'b11) begin
      errors++; $display("FAIL pre_rst_high: got scl/busy=%b need 11", {scl_out, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({scl_out, busy, sda_en, sample_stb, period_end, stretching} !== 6'b100000) begin
      errors++; $display("FAIL async_rst: got %b need 100000",
                         {scl_out, busy, sda_en, sample_stb, period_end, stretching});
    end
    en = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    repeat (3) @(negedge clk_in);
    checks++;
    if ({scl_out, busy} !== 2'b10) begin
      errors++; $display("FAIL post_rst_idle: got scl/busy=%b need 10", {scl_out, busy});
    end
  endtask

  task automatic test_clamp;
    sel = 1'b1;
    cfg2 = 2'b11;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(2, 0));
    en2 = 1'b1;
    wait_obs(2, 100);
    en2 = 1'b0;
    wait_obs(3, 50);
    wait_idle(20);
    checks++;
    if (obs_q.size() < exp_q.size()) begin
      errors++; $display("FAIL clamp_timeout: got %0d records need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL clamp_period: got %s need %s", fmt(o), fmt(e)); end
    end
    exp_q.delete(); obs_q.delete();
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_hs;
    test_sm_stop;
    test_stretch;
    test_mode_change;
    test_back_to_back;
    test_async_reset;
    test_clamp;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
